mxbiu_prefetch: RTL
===================

MXBIU_PREFETCH -- requirements
Module: mxbiu_prefetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the bus and fetch pointer address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, the prefetch queue entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports m0_rd_txn_start out 1, m0_rd_addr out ADDR_WIDTH, m0_rd_data in DATA_WIDTH, m0_rd_ready in 1, m0_rd_txn_ack in 1, m0_rd_txn_cpl in 1; MX Bus read master.
REQ-007 SHALL have port fetch_en  in  1  high permits new prefetch issue.
REQ-008 SHALL have ports redirect in 1, redirect_addr in ADDR_WIDTH; flush queue and restart fetch at redirect_addr.
REQ-009 SHALL have ports insr out DATA_WIDTH, insp out ADDR_WIDTH; queue-head word and its address.
REQ-010 SHALL have ports valid out 1, pop in 1; head valid, consumer accepts head.

Function
REQ-011 Fetch FSM SHALL have states IDLE, START, WAIT.
REQ-012 IDLE->START when fetch_en & m0_rd_ready & ~redirect & (occupancy + 0) < DEPTH; latch m0_rd_addr <= fp, assert m0_rd_txn_start next cycle.
REQ-013 START: m0_rd_txn_start SHALL stay high until m0_rd_txn_ack; ack&~cpl -> WAIT; ack&cpl -> IDLE with completion.
REQ-014 WAIT->IDLE on m0_rd_txn_cpl with completion; m0_rd_txn_start low in WAIT.
REQ-015 Completion SHALL push {m0_rd_addr, m0_rd_data} into queue and increment fp by 1 (modulo 2^ADDR_WIDTH, wrap from all-ones to 0).
REQ-016 At most one transaction outstanding; issue gating SHALL count the in-flight slot so a completion never finds the queue full.
REQ-017 valid SHALL be high iff queue non-empty; insr/insp SHALL show head combinationally from queue storage.
REQ-018 pop & valid SHALL retire head next edge; pop while empty SHALL be ignored.
REQ-019 Push and pop same cycle SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-020 redirect SHALL, next edge, empty the queue, set fp <= redirect_addr, and set discard flag if a transaction is in START or WAIT.
REQ-021 With discard set, the pending transaction SHALL run to cpl normally but its data SHALL NOT be pushed and fp SHALL NOT increment; discard clears on that cpl.
REQ-022 redirect SHALL take priority over pop, push and issue in the same cycle; a cpl coinciding with redirect SHALL be discarded.
REQ-023 redirect with fetch_en low SHALL still flush and load fp.

Reset
REQ-024 rst SHALL set FSM IDLE, m0_rd_txn_start 0, m0_rd_addr 0, fp 0, queue empty, valid 0, discard 0; insr/insp SHALL read 0 after reset.
REQ-025 rst mid-transaction SHALL abandon it without waiting for ack/cpl; rst overrides redirect.

Configuration
REQ-026 With MXBIU_PREFETCH_OCC_EN defined, SHALL add port occupancy out $clog2(DEPTH)+1 giving current queue entry count, 0 on reset.
REQ-027 Without MXBIU_PREFETCH_OCC_EN, port SHALL be absent and behaviour otherwise identical.

Verification
REQ-028 Reset, fetch_en=1, bus acks+cpls same cycle with data=addr^8'hA5, no pop -> addresses 0,1,2,3 fetched, then issue stops; valid=1, insp=0, insr=8'hA5.
REQ-029 Full queue, pop held 4 cycles -> insp 0,1,2,3 in order, refetch of 4 begins, no entry lost or duplicated.
REQ-030 Ack at cycle N, cpl at N+3 -> m0_rd_txn_start high until N only, push at N+3, no second start before push.
REQ-031 redirect_addr=8'h40 while in WAIT -> queue empties next edge, late cpl data dropped, next start carries m0_rd_addr=8'h40.
REQ-032 redirect_addr=8'hFE, fetch_en=1 -> fetched addresses FE, FF, 00, 01 (wrap).
REQ-033 rst asserted in START -> start drops next edge, valid=0, fp=0; with MXBIU_PREFETCH_OCC_EN, occupancy tracks 0..4 in REQ-028 and returns 0 after redirect.

Source files
------------

// File: rtl/mxbiu_prefetch.sv
// MX Bus instruction prefetcher: one outstanding read feeding a DEPTH-entry queue.
// Define MXBIU_PREFETCH_OCC_EN to expose the queue entry count on port occupancy.
module mxbiu_prefetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    m0_rd_txn_start,
  output logic [ADDR_WIDTH-1:0]   m0_rd_addr,
  input  logic [DATA_WIDTH-1:0]   m0_rd_data,
  input  logic                    m0_rd_ready,
  input  logic                    m0_rd_txn_ack,
  input  logic                    m0_rd_txn_cpl,
  input  logic                    fetch_en,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  output logic [DATA_WIDTH-1:0]   insr,
  output logic [ADDR_WIDTH-1:0]   insp,
  output logic                    valid,
`ifdef MXBIU_PREFETCH_OCC_EN
  output logic [$clog2(DEPTH):0]  occupancy,
`endif
  input  logic                    pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_qdata [DEPTH];
  logic [ADDR_WIDTH-1:0] r_qaddr [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_discard;
  logic                  w_issue, w_cpl, w_push, w_pop;

  // Issue only from IDLE, so the single in-flight slot is always backed by a free entry.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_cpl       = 1'b0;
    case (r_state)
      IDLE: begin
        if (fetch_en && m0_rd_ready && !redirect && (r_count < FULL)) begin
          w_issue     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (m0_rd_txn_ack) begin
          if (m0_rd_txn_cpl) begin
            w_cpl       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (m0_rd_txn_cpl) begin
          w_cpl       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_push = w_cpl && !r_discard && !redirect;
  assign w_pop  = pop && valid && !redirect;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fp      <= '0;
      r_addr    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_discard <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_qdata[i] <= '0;
        r_qaddr[i] <= '0;
      end
    end else begin
      if (w_issue) r_addr <= r_fp;
      if (redirect) begin
        r_fp      <= redirect_addr;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        // A transaction finishing this very cycle is already dropped; only a still-pending one needs the flag.
        r_discard <= (r_state != IDLE) && !w_cpl;
      end else begin
        if (w_cpl) r_discard <= 1'b0;
        if (w_push) begin
          r_qdata[r_wptr] <= m0_rd_data;
          r_qaddr[r_wptr] <= r_addr;
          r_wptr          <= r_wptr + 1'b1;
          r_fp            <= r_fp + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign m0_rd_txn_start = (r_state == START);
  assign m0_rd_addr      = r_addr;
  assign valid           = (r_count != '0);
  assign insr            = r_qdata[r_rptr];
  assign insp            = r_qaddr[r_rptr];
`ifdef MXBIU_PREFETCH_OCC_EN
  assign occupancy       = r_count;
`endif

endmodule
